// File: rtl/ctrl_word_sequencer.sv
// rtl/ctrl_word_sequencer.sv - programmable control-word table player
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   wr_en      write table entry wr_addr with {wr_word, wr_hold}
//   wr_addr    table entry index
//   wr_word    control word to store
//   wr_hold    hold count h; stored word is driven for h+1 cycles
//   length     number of entries to play from entry 0 (sampled at start)
//   loop_mode  wrap to entry 0 after the last entry (sampled at start)
//   start      begin playback
//   stop       abort playback
//   ctrl_word  control word to SYSTEM, 0 when idle
//   ctrl_valid ctrl_word comes from the table
//   busy       playback in progress
//   done       one-cycle pulse on normal completion
//   step_idx   entry currently driven
module ctrl_word_sequencer #(
   parameter int CW_WIDTH   = 21,
   parameter int DEPTH      = 16,
   parameter int HOLD_WIDTH = 4,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [CW_WIDTH-1:0]   wr_word,
   input  logic [HOLD_WIDTH-1:0] wr_hold,
   input  logic [AW:0]           length,
   input  logic                  loop_mode,
   input  logic                  start,
   input  logic                  stop,
   output logic [CW_WIDTH-1:0]   ctrl_word,
   output logic                  ctrl_valid,
   output logic                  busy,
   output logic                  done,
   output logic [AW-1:0]         step_idx
);

   typedef enum logic [0:0] {IDLE, PLAY} state_t;

   localparam logic [AW:0]         DEPTH_L  = (AW + 1)'(DEPTH);
   localparam logic [AW:0]         LEN_ONE  = (AW + 1)'(1);
   localparam logic [AW-1:0]       STEP_ONE = AW'(1);
   localparam logic [HOLD_WIDTH-1:0] HOLD_ONE = HOLD_WIDTH'(1);

   state_t                  state_q, state_d;
   logic [CW_WIDTH-1:0]     word_tab_q [DEPTH];
   logic [CW_WIDTH-1:0]     word_tab_d [DEPTH];
   logic [HOLD_WIDTH-1:0]   hold_tab_q [DEPTH];
   logic [HOLD_WIDTH-1:0]   hold_tab_d [DEPTH];
   logic [CW_WIDTH-1:0]     ctrl_word_q, ctrl_word_d;
   logic                    ctrl_valid_q, ctrl_valid_d;
   logic                    done_q, done_d;
   logic [AW-1:0]           step_q, step_d;
   logic [HOLD_WIDTH-1:0]   hold_cnt_q, hold_cnt_d;
   logic [AW:0]             len_q, len_d;
   logic                    loop_q, loop_d;

   logic [AW:0]             len_sat;
   logic                    at_last;
   logic [AW-1:0]           next_step;

   // Lengths beyond the table size play the whole table once per pass.
   assign len_sat   = (length > DEPTH_L) ? DEPTH_L : length;
   assign at_last   = ({1'b0, step_q} == (len_q - LEN_ONE));
   assign next_step = step_q + STEP_ONE;

   // Table writes land at the edge; loads below read the pre-edge table,
   // so a same-edge write to the entry being loaded shows on the next visit.
   always_comb begin
      word_tab_d = word_tab_q;
      hold_tab_d = hold_tab_q;
      if (wr_en) begin
         word_tab_d[wr_addr] = wr_word;
         hold_tab_d[wr_addr] = wr_hold;
      end
   end

   always_comb begin
      state_d      = state_q;
      ctrl_word_d  = ctrl_word_q;
      ctrl_valid_d = ctrl_valid_q;
      done_d       = 1'b0;
      step_d       = step_q;
      hold_cnt_d   = hold_cnt_q;
      len_d        = len_q;
      loop_d       = loop_q;

      case (state_q)
         IDLE: begin
            if (start && !stop && (length != '0)) begin
               state_d      = PLAY;
               len_d        = len_sat;
               loop_d       = loop_mode;
               ctrl_word_d  = word_tab_q[0];
               hold_cnt_d   = hold_tab_q[0];
               step_d       = '0;
               ctrl_valid_d = 1'b1;
            end
         end
         PLAY: begin
            if (stop) begin
               state_d      = IDLE;
               ctrl_word_d  = '0;
               ctrl_valid_d = 1'b0;
               step_d       = '0;
               hold_cnt_d   = '0;
            end else if (hold_cnt_q != '0) begin
               hold_cnt_d = hold_cnt_q - HOLD_ONE;
            end else if (!at_last) begin
               ctrl_word_d = word_tab_q[next_step];
               hold_cnt_d  = hold_tab_q[next_step];
               step_d      = next_step;
            end else if (loop_q) begin
               ctrl_word_d = word_tab_q[0];
               hold_cnt_d  = hold_tab_q[0];
               step_d      = '0;
            end else begin
               state_d      = IDLE;
               ctrl_word_d  = '0;
               ctrl_valid_d = 1'b0;
               step_d       = '0;
               done_d       = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         ctrl_word_q  <= '0;
         ctrl_valid_q <= 1'b0;
         done_q       <= 1'b0;
         step_q       <= '0;
         hold_cnt_q   <= '0;
         len_q        <= '0;
         loop_q       <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            word_tab_q[i] <= '0;
            hold_tab_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         ctrl_word_q  <= ctrl_word_d;
         ctrl_valid_q <= ctrl_valid_d;
         done_q       <= done_d;
         step_q       <= step_d;
         hold_cnt_q   <= hold_cnt_d;
         len_q        <= len_d;
         loop_q       <= loop_d;
         word_tab_q   <= word_tab_d;
         hold_tab_q   <= hold_tab_d;
      end
   end

   assign ctrl_word  = ctrl_word_q;
   assign ctrl_valid = ctrl_valid_q;
   assign busy       = (state_q == PLAY);
   assign done       = done_q;
   assign step_idx   = step_q;

endmodule

// File: tb/tb_ctrl_word_sequencer.sv
// tb/tb_ctrl_word_sequencer.sv - directed self-checking bench for ctrl_word_sequencer
module tb_ctrl_word_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [20:0] wr_word;
   logic [3:0]  wr_hold;
   logic [4:0]  length;
   logic        loop_mode;
   logic        start;
   logic        stop;
   logic [20:0] ctrl_word;
   logic        ctrl_valid;
   logic        busy;
   logic        done;
   logic [3:0]  step_idx;

   int checks = 0;
   int errors = 0;

   // {ctrl_word, ctrl_valid, busy, done, step_idx}
   logic [27:0] obs;
   assign obs = {ctrl_word, ctrl_valid, busy, done, step_idx};

   always #5 clk = ~clk;

   ctrl_word_sequencer #(
      .CW_WIDTH  (21),
      .DEPTH     (16),
      .HOLD_WIDTH(4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_word   (wr_word),
      .wr_hold   (wr_hold),
      .length    (length),
      .loop_mode (loop_mode),
      .start     (start),
      .stop      (stop),
      .ctrl_word (ctrl_word),
      .ctrl_valid(ctrl_valid),
      .busy      (busy),
      .done      (done),
      .step_idx  (step_idx)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_entry(input int a, input logic [20:0] w, input logic [3:0] h);
      wr_en   = 1'b1;
      wr_addr = a[3:0];
      wr_word = w;
      wr_hold = h;
      step();
      wr_en   = 1'b0;
   endtask

   task automatic load_basic_table();
      write_entry(0, 21'h02000, 4'd0);
      write_entry(1, 21'h00001, 4'd0);
      write_entry(2, 21'h10030, 4'd2);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if (obs !== 28'h0) begin
            errors++;
            $display("FAIL reset_hold cyc %0d got %h want %h", c, obs, 28'h0);
         end
      end
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         step();
         checks++;
         if (obs !== 28'h0) begin
            errors++;
            $display("FAIL idle_after_reset cyc %0d got %h want %h", c, obs, 28'h0);
         end
      end
   endtask

   task automatic test_single_play();
      logic [27:0] exp [7];
      exp[0] = {21'h02000, 1'b1, 1'b1, 1'b0, 4'd0};
      exp[1] = {21'h00001, 1'b1, 1'b1, 1'b0, 4'd1};
      exp[2] = {21'h10030, 1'b1, 1'b1, 1'b0, 4'd2};
      exp[3] = {21'h10030, 1'b1, 1'b1, 1'b0, 4'd2};
      exp[4] = {21'h10030, 1'b1, 1'b1, 1'b0, 4'd2};
      exp[5] = {21'h00000, 1'b0, 1'b0, 1'b1, 4'd0};
      exp[6] = {21'h00000, 1'b0, 1'b0, 1'b0, 4'd0};
      load_basic_table();
      length    = 5'd3;
      loop_mode = 1'b0;
      start     = 1'b1;
      for (int c = 0; c < 7; c++) begin
         step();
         if (c == 0) start = 1'b0;
         checks++;
         if (obs !== exp[c]) begin
            errors++;
            $display("FAIL single_play cyc %0d got %h want %h", c, obs, exp[c]);
         end
      end
   endtask

   task automatic test_loop_stop();
      logic [20:0] w;
      logic [3:0]  s;
      logic [27:0] e;
      length    = 5'd3;
      loop_mode = 1'b1;
      start     = 1'b1;
      for (int c = 0; c < 12; c++) begin
         step();
         if (c == 0) start = 1'b0;
         s = ((c % 5) < 2) ? 4'(c % 5) : 4'd2;
         w = (s == 4'd0) ? 21'h02000 : (s == 4'd1) ? 21'h00001 : 21'h10030;
         e = {w, 1'b1, 1'b1, 1'b0, s};
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL loop_play cyc %0d got %h want %h", c, obs, e);
         end
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      checks++;
      if (obs !== 28'h0) begin
         errors++;
         $display("FAIL loop_stop got %h want %h", obs, 28'h0);
      end
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if (obs !== 28'h0) begin
            errors++;
            $display("FAIL after_stop cyc %0d got %h want %h", c, obs, 28'h0);
         end
      end
   endtask

   task automatic test_length_zero();
      length    = 5'd0;
      loop_mode = 1'b0;
      start     = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if (obs !== 28'h0) begin
            errors++;
            $display("FAIL length_zero cyc %0d got %h want %h", c, obs, 28'h0);
         end
      end
      start = 1'b0;
   endtask

   task automatic test_start_stop_same();
      length = 5'd3;
      start  = 1'b1;
      stop   = 1'b1;
      for (int c = 0; c < 2; c++) begin
         step();
         checks++;
         if (obs !== 28'h0) begin
            errors++;
            $display("FAIL start_stop_same cyc %0d got %h want %h", c, obs, 28'h0);
         end
      end
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic test_start_while_busy();
      logic [27:0] exp [6];
      exp[0] = {21'h02000, 1'b1, 1'b1, 1'b0, 4'd0};
      exp[1] = {21'h00001, 1'b1, 1'b1, 1'b0, 4'd1};
      exp[2] = {21'h10030, 1'b1, 1'b1, 1'b0, 4'd2};
      exp[3] = {21'h10030, 1'b1, 1'b1, 1'b0, 4'd2};
      exp[4] = {21'h10030, 1'b1, 1'b1, 1'b0, 4'd2};
      exp[5] = {21'h00000, 1'b0, 1'b0, 1'b1, 4'd0};
      length    = 5'd3;
      loop_mode = 1'b0;
      start     = 1'b1;
      for (int c = 0; c < 6; c++) begin
         step();
         start = 1'b0;
         if (c == 1) begin
            start  = 1'b1;
            length = 5'd1;
         end
         checks++;
         if (obs !== exp[c]) begin
            errors++;
            $display("FAIL start_while_busy cyc %0d got %h want %h", c, obs, exp[c]);
         end
      end
      start = 1'b0;
      step();
   endtask

   task automatic test_back_to_back();
      logic [27:0] e_done;
      logic [27:0] e_first;
      e_done  = {21'h00000, 1'b0, 1'b0, 1'b1, 4'd0};
      e_first = {21'h02000, 1'b1, 1'b1, 1'b0, 4'd0};
      length    = 5'd3;
      loop_mode = 1'b0;
      start     = 1'b1;
      step();
      start = 1'b0;
      repeat (5) step();
      checks++;
      if (obs !== e_done) begin
         errors++;
         $display("FAIL b2b_done got %h want %h", obs, e_done);
      end
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (obs !== e_first) begin
         errors++;
         $display("FAIL b2b_restart got %h want %h", obs, e_first);
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
   endtask

   task automatic test_max_hold();
      logic [27:0] e;
      write_entry(0, 21'h0AAAA, 4'd15);
      length    = 5'd1;
      loop_mode = 1'b0;
      start     = 1'b1;
      for (int c = 0; c < 17; c++) begin
         step();
         if (c == 0) start = 1'b0;
         e = (c < 16) ? {21'h0AAAA, 1'b1, 1'b1, 1'b0, 4'd0}
                      : {21'h00000, 1'b0, 1'b0, 1'b1, 4'd0};
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL max_hold cyc %0d got %h want %h", c, obs, e);
         end
      end
   endtask

   task automatic test_length_over();
      logic [27:0] e;
      for (int i = 0; i < 16; i++) write_entry(i, 21'h100 + 21'(i), 4'd0);
      length    = 5'd21;
      loop_mode = 1'b0;
      start     = 1'b1;
      for (int c = 0; c < 17; c++) begin
         step();
         if (c == 0) start = 1'b0;
         e = (c < 16) ? {21'h100 + 21'(c), 1'b1, 1'b1, 1'b0, 4'(c)}
                      : {21'h00000, 1'b0, 1'b0, 1'b1, 4'd0};
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL length_over cyc %0d got %h want %h", c, obs, e);
         end
      end
   endtask

   task automatic test_live_write();
      logic [20:0] w;
      logic [3:0]  s;
      logic [27:0] e;
      load_basic_table();
      length    = 5'd3;
      loop_mode = 1'b1;
      start     = 1'b1;
      for (int c = 0; c < 11; c++) begin
         step();
         start = 1'b0;
         wr_en = 1'b0;
         if (c == 0) begin
            wr_en   = 1'b1;
            wr_addr = 4'd1;
            wr_word = 21'h1FFFF;
            wr_hold = 4'd0;
         end
         s = ((c % 5) < 2) ? 4'(c % 5) : 4'd2;
         w = (s == 4'd0) ? 21'h02000 :
             (s == 4'd1) ? ((c < 5) ? 21'h00001 : 21'h1FFFF) : 21'h10030;
         e = {w, 1'b1, 1'b1, 1'b0, s};
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL live_write cyc %0d got %h want %h", c, obs, e);
         end
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [27:0] exp [3];
      logic [27:0] e;
      exp[0] = {21'h02000, 1'b1, 1'b1, 1'b0, 4'd0};
      exp[1] = {21'h1FFFF, 1'b1, 1'b1, 1'b0, 4'd1};
      exp[2] = {21'h10030, 1'b1, 1'b1, 1'b0, 4'd2};
      length    = 5'd3;
      loop_mode = 1'b0;
      start     = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         start = 1'b0;
         checks++;
         if (obs !== exp[c]) begin
            errors++;
            $display("FAIL pre_reset cyc %0d got %h want %h", c, obs, exp[c]);
         end
      end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      checks++;
      if (obs !== 28'h0) begin
         errors++;
         $display("FAIL reset_mid got %h want %h", obs, 28'h0);
      end
      step();
      start = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         start = 1'b0;
         e = (c < 3) ? {21'h00000, 1'b1, 1'b1, 1'b0, 4'(c)}
                     : {21'h00000, 1'b0, 1'b0, 1'b1, 4'd0};
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL cleared_table cyc %0d got %h want %h", c, obs, e);
         end
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_word   = '0;
      wr_hold   = '0;
      length    = '0;
      loop_mode = 1'b0;
      start     = 1'b0;
      stop      = 1'b0;
      #2;
      test_reset();
      test_single_play();
      test_loop_stop();
      test_length_zero();
      test_start_stop_same();
      test_start_while_busy();
      test_back_to_back();
      test_max_hold();
      test_length_over();
      test_live_write();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ctrl_word_sequencer.md
# ctrl_word_sequencer

Synthesisable, parametrised player for SYSTEM main-control words. It replaces hand-stepped control-word stimulus with a programmable table of up to DEPTH words. Each word is held on the output for a programmable number of cycles and is played once or looped. It sits between the host/bench and SYSTEM's control-signal input, sharing SYSTEM's clock.

## Interface
Parameters:
- CW_WIDTH, 21, width of one control word
- DEPTH, 16, table entries (power of two, ≥2); AW = clog2(DEPTH)
- HOLD_WIDTH, 4, width of per-entry hold count

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset: synchronous, active-low
- wr_en  in  1  write table entry this cycle
- wr_addr  in  AW  entry index
- wr_word  in  CW_WIDTH  control word to store
- wr_hold  in  HOLD_WIDTH  hold count h; the word is driven for h+1 cycles
- length  in  AW+1  number of entries to play, counted from entry 0; sampled at start
- loop_mode  in  1  1 = wrap to entry 0 after the last entry; sampled at start
- start  in  1  begin playback (level sampled at the edge)
- stop  in  1  abort playback
- ctrl_word  out  CW_WIDTH  control word to SYSTEM; 0 = NOP
- ctrl_valid  out  1  ctrl_word comes from the table
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse on normal completion
- step_idx  out  AW  entry currently driven

## Operation
- Storage: DEPTH×(CW_WIDTH+HOLD_WIDTH) register table, cleared to 0 by reset. Writes are accepted in any state.
- Read-before-write: an entry is latched into ctrl_word/hold counter only at the edge where it is loaded. A same-edge write to that entry is seen on the next visit.
- States: IDLE, PLAY.
- IDLE → PLAY on start=1, stop=0 and length≠0.
  - Latch len = min(length, DEPTH) and loop_mode.
  - Load entry 0: ctrl_word=word[0], hold counter=hold[0], step_idx=0, ctrl_valid=1.
- start with length=0 is ignored. start while in PLAY is ignored.
- PLAY, hold counter ≠ 0: decrement the counter; outputs unchanged.
- PLAY, hold counter = 0 and step_idx < len−1: load entry step_idx+1.
- PLAY, hold counter = 0 and step_idx = len−1:
  - If latched loop=1: load entry 0 (wrap).
  - If latched loop=0: go to IDLE with ctrl_word=0, ctrl_valid=0, step_idx=0, and done=1 for exactly this one cycle.
- stop=1 in PLAY: go to IDLE at that edge with ctrl_word=0, ctrl_valid=0, step_idx=0, done=0. stop is the only exit from loop mode.
- stop and start in the same cycle: stop wins, so the block stays or goes IDLE.
- Mid-operation reset (rst_n=0 at an edge) takes effect at that edge.
  - State=IDLE; all outputs 0; table cleared.
  - done is not pulsed.

## Timing
- Reset values: ctrl_word=0, ctrl_valid=0, busy=0, done=0, step_idx=0.
- Start latency: start sampled at edge k → word[0] on ctrl_word and busy=1 from edge k.
- Entry i is driven for exactly hold[i]+1 cycles. There is no gap cycle between entries or across a wrap.
- Non-loop run of L entries: busy high for Σ(hold[i]+1) cycles. done is high in the first cycle after that, coincident with ctrl_word returning to 0 and busy=0.
- Back-to-back runs: a new start is accepted in the same cycle done is high, because the state is IDLE then. The next run's word[0] then appears one edge later.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset/idle: hold rst_n=0 for 3 cycles, then release with no start → ctrl_word=0, ctrl_valid=0, busy=0, done=0 for 10 cycles.
- Single play: load {0x02000 h0, 0x00001 h0, 0x10030 h2}, length=3, loop=0, start at edge k.
  - Expect 0x02000 @k, 0x00001 @k+1, 0x10030 @k+2..k+4.
  - Expect 0 with done=1 @k+5, and busy=0 from k+5.
- Loop and stop: same table with loop=1.
  - Sequence repeats with period 5 cycles and no gap at the wrap.
  - stop at cycle 12 of the run → ctrl_word=0 at that edge, done never asserted.
- Boundaries:
  - length=0 start → no activity.
  - length=DEPTH+5 → plays exactly DEPTH entries.
  - hold=2^HOLD_WIDTH−1 → entry held 16 cycles.
  - start asserted while busy → ignored.
  - start and stop in the same cycle → stays IDLE.
- Live write: during a looped run, write entry 1 = 0x1FFFF in the same cycle entry 1 is loaded.
  - Old value is shown on this pass; 0x1FFFF appears on the next pass.
- Reset mid-run: rst_n=0 while entry 2 is active → all outputs 0 next edge; after release, start plays all-zero words (table cleared).
